// File: rtl/fifo_wr_ctrl_if.sv
// Write-side port bundle of the async FIFO controller: request/flag signals
// exchanged between the write-domain logic and its environment.
interface fifo_wr_ctrl_if #(
    parameter int ADDRESS = 4
);
    logic                 W_INC;
    logic                 OVF_CLR;
    logic [ADDRESS-1:0]   WQ2_RPTR;
    logic                 W_CLKEN;
    logic [ADDRESS-2:0]   W_ADDR;
    logic [ADDRESS-1:0]   W_PTR;
    logic                 W_FULL;
    logic                 W_ALMOST_FULL;
    logic [ADDRESS-1:0]   W_LEVEL;
    logic                 W_OVERFLOW;

    modport master (
        output W_INC, OVF_CLR, WQ2_RPTR,
        input  W_CLKEN, W_ADDR, W_PTR, W_FULL, W_ALMOST_FULL, W_LEVEL, W_OVERFLOW
    );

    modport slave (
        input  W_INC, OVF_CLR, WQ2_RPTR,
        output W_CLKEN, W_ADDR, W_PTR, W_FULL, W_ALMOST_FULL, W_LEVEL, W_OVERFLOW
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of a Gray-pointer async FIFO: write pointer,
// full/almost-full/level flags and a sticky overflow indicator.
module fifo_wr_ctrl #(
    parameter int ADDRESS  = 4,
    parameter int AF_LEVEL = 6
) (
    input  logic           W_CLK,
    input  logic           W_RST,
    fifo_wr_ctrl_if.slave  wif
);
    localparam logic [ADDRESS-1:0] ONE       = ADDRESS'(1);
    localparam logic [ADDRESS-1:0] AF_THRESH = ADDRESS'(AF_LEVEL);
    // Full when the write pointer is exactly one lap ahead: top two Gray bits differ.
    localparam logic [ADDRESS-1:0] MSB2_MASK = {2'b11, {(ADDRESS-2){1'b0}}};

    function automatic logic [ADDRESS-1:0] bin2gray(input logic [ADDRESS-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDRESS-1:0] gray2bin(input logic [ADDRESS-1:0] g);
        logic [ADDRESS-1:0] b;
        b[ADDRESS-1] = g[ADDRESS-1];
        for (int i = ADDRESS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRESS-1:0] wbin_q,  wbin_d;
    logic [ADDRESS-1:0] wptr_q,  wptr_d;
    logic               full_q,  full_d;
    logic               afull_q, afull_d;
    logic [ADDRESS-1:0] level_q, level_d;
    logic               ovf_q,   ovf_d;
    logic               clken_s;
    logic [ADDRESS-1:0] rbin_s;

    // Next-state computation for pointer, flags and sticky overflow.
    always_comb begin
        clken_s = wif.W_INC & (W_RST | ~full_q);
        rbin_s  = gray2bin(wif.WQ2_RPTR);
        if (clken_s) begin
            wbin_d = wbin_q + ONE;
        end else begin
            wbin_d = wbin_q;
        end
        wptr_d  = bin2gray(wbin_d);
        full_d  = (wptr_d == (wif.WQ2_RPTR ^ MSB2_MASK));
        level_d = wbin_d - rbin_s;
        afull_d = (level_d >= AF_THRESH);
        // Set has priority over clear so a refused write is never lost.
        if (wif.W_INC & full_q) begin
            ovf_d = 1'b1;
        end else if (wif.OVF_CLR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge W_CLK) begin
        if (W_RST) begin
            wbin_q  <= {ADDRESS{1'b0}};
            wptr_q  <= {ADDRESS{1'b0}};
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            level_q <= {ADDRESS{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wif.W_CLKEN       = clken_s;
    assign wif.W_ADDR        = W_RST ? {(ADDRESS-1){1'b0}} : wbin_q[ADDRESS-2:0];
    assign wif.W_PTR         = wptr_q;
    assign wif.W_FULL        = full_q;
    assign wif.W_ALMOST_FULL = afull_q;
    assign wif.W_LEVEL       = level_q;
    assign wif.W_OVERFLOW    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: occupancy model in plain integers,
// directed fill/overflow/wrap/reset sequences followed by random traffic.
module tb_fifo_wr_ctrl;
    localparam int ADDRESS  = 4;
    localparam int AF_LEVEL = 6;
    localparam int DEPTH    = 8;

    typedef struct {
        bit       rst;
        bit       accepted;
        bit [3:0] ptr;
        bit       full;
        bit       af;
        int       level;
        bit       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t expq[$];
    int   wr_cnt  = 0;
    int   rd_cnt  = 0;
    int   m_level = 0;
    bit   m_full  = 1'b0;
    bit   m_ovf   = 1'b0;

    fifo_wr_ctrl_if #(.ADDRESS(ADDRESS)) wif ();

    fifo_wr_ctrl #(.ADDRESS(ADDRESS), .AF_LEVEL(AF_LEVEL)) dut (
        .W_CLK (clk),
        .W_RST (rst),
        .wif   (wif)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] gray(input int v);
        int b;
        b = v % 16;
        return 4'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model result is queued for the monitor.
    task automatic step(input bit rst_i, input bit inc_i, input bit clr_i, input int rd_adv);
        exp_t e;
        @(negedge clk);
        if (rst_i) rd_cnt = 0;
        else rd_cnt = (rd_cnt + rd_adv > wr_cnt) ? wr_cnt : rd_cnt + rd_adv;
        rst          = rst_i;
        wif.W_INC    = inc_i;
        wif.OVF_CLR  = clr_i;
        wif.WQ2_RPTR = gray(rd_cnt);
        #1;
        chk("w_clken", wif.W_CLKEN, inc_i && (rst_i || !m_full));
        chk("w_addr", wif.W_ADDR, rst_i ? 0 : wr_cnt % DEPTH);
        e.rst = rst_i;
        e.accepted = 1'b0;
        if (rst_i) begin
            wr_cnt = 0;
            m_ovf  = 1'b0;
        end else begin
            e.accepted = inc_i && !m_full;
            if (e.accepted) wr_cnt++;
            if (inc_i && m_full) m_ovf = 1'b1;
            else if (clr_i) m_ovf = 1'b0;
        end
        m_level = wr_cnt - rd_cnt;
        m_full  = (m_level == DEPTH);
        e.ptr   = gray(wr_cnt);
        e.level = m_level;
        e.full  = m_full;
        e.af    = (m_level >= AF_LEVEL);
        e.ovf   = m_ovf;
        expq.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: after each edge pop the expected registered state and compare.
    initial begin : monitor
        exp_t     e;
        bit       have_prev = 1'b0;
        bit [3:0] prev_ptr  = 4'b0000;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("w_ptr", wif.W_PTR, e.ptr);
                chk("w_full", wif.W_FULL, e.full);
                chk("w_almost_full", wif.W_ALMOST_FULL, e.af);
                chk("w_level", wif.W_LEVEL, e.level);
                chk("w_overflow", wif.W_OVERFLOW, e.ovf);
                chk("level_bound", wif.W_LEVEL <= DEPTH, 1);
                if (!e.rst && have_prev)
                    chk("ptr_one_bit", $countones(wif.W_PTR ^ prev_ptr), e.accepted ? 1 : 0);
                prev_ptr  = wif.W_PTR;
                have_prev = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : stimulus
        wif.W_INC    = 1'b0;
        wif.OVF_CLR  = 1'b0;
        wif.WQ2_RPTR = 4'b0000;
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);

        // Fill to full.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 0);
        #2;
        chk("fill_ptr", wif.W_PTR, 4'b1100);
        chk("fill_full", wif.W_FULL, 1'b1);
        chk("fill_level", wif.W_LEVEL, 4'd8);

        // Overflow and clear behaviour.
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        #2;
        chk("ovf_set", wif.W_OVERFLOW, 1'b1);
        chk("ovf_ptr_hold", wif.W_PTR, 4'b1100);
        step(1'b0, 1'b0, 1'b1, 0);
        #2;
        chk("ovf_clr", wif.W_OVERFLOW, 1'b0);
        step(1'b0, 1'b1, 1'b1, 0);
        #2;
        chk("ovf_set_wins", wif.W_OVERFLOW, 1'b1);

        // Reader drains everything; refill across the pointer wrap.
        step(1'b0, 1'b0, 1'b1, 8);
        #2;
        chk("drain_full", wif.W_FULL, 1'b0);
        chk("drain_level", wif.W_LEVEL, 4'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 0);
        #2;
        chk("wrap_ptr", wif.W_PTR, 4'b0000);
        chk("wrap_full", wif.W_FULL, 1'b1);
        chk("wrap_level", wif.W_LEVEL, 4'd8);

        // Reset in the middle of traffic.
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        #2;
        chk("rst_mid_level", wif.W_LEVEL, 4'd0);
        chk("rst_mid_ptr", wif.W_PTR, 4'd0);
        chk("rst_mid_full", {wif.W_FULL, wif.W_ALMOST_FULL, wif.W_OVERFLOW}, 3'b000);

        // Random traffic: write-heavy first half, balanced second half.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0,
                 (i < 200) ? int'($urandom_range(0, 2) == 0) : int'($urandom_range(0, 2)));
        end
        step(1'b0, 1'b0, 1'b0, 0);
        #5;
        chk("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
